// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings, FSM state encoding and memory depth default for the load/store unit.
package lsu_pkg;

   localparam int LSU_MEM_WORDS = 256;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ERR  = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_READ  = 3'd2,
      S_WRITE = 3'd3,
      S_RESP  = 3'd4
   } state_e;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: little-endian lane extract/extend for loads and lane merge for sub-word stores.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic        i_unsigned,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_rword,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_ldata,
   output logic [31:0] o_mword
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_mask;
   logic [31:0] w_wrep;

   // half lanes use only off[1], so a misaligned half is silently aligned; words ignore the offset
   always_comb begin
      w_byte  = 8'(i_rword >> {i_off, 3'b000});
      w_half  = 16'(i_rword >> {i_off[1], 4'b0000});
      w_mask  = (i_size == SZ_BYTE) ? (32'h0000_00FF << {i_off, 3'b000}) :
                (i_size == SZ_HALF) ? (32'h0000_FFFF << {i_off[1], 4'b0000}) : 32'hFFFF_FFFF;
      w_wrep  = (i_size == SZ_BYTE) ? {4{i_wdata[7:0]}} :
                (i_size == SZ_HALF) ? {2{i_wdata[15:0]}} : i_wdata;
      o_mword = (i_rword & ~w_mask) | (w_wrep & w_mask);
      o_ldata = (i_size == SZ_BYTE) ? (i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte}) :
                (i_size == SZ_HALF) ? (i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half}) : i_rword;
   end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store sequencer for a single-port word memory.
// Build option LSU_MISALIGN_TRAP_EN: misaligned half/word accesses report an error instead of being aligned.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_WORDS = LSU_MEM_WORDS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] addr,
   output logic [31:0] data2,
   output logic        lw_en,
   output logic        sw_en,
   input  logic [31:0] data_mem
);

   state_e      r_state;
   logic        r_we;
   logic [1:0]  r_size;
   logic        r_unsigned;
   logic [1:0]  r_off;
   logic [31:0] r_wdata;
   logic [31:0] r_addr;
   logic [31:0] r_data2;
   logic        r_lw_en;
   logic        r_sw_en;
   logic        r_resp_valid;
   logic        r_resp_err;
   logic [31:0] r_resp_rdata;
   logic        w_misalign;
   logic        w_err;
   logic [31:0] w_ldata;
   logic [31:0] w_mword;

`ifdef LSU_MISALIGN_TRAP_EN
   assign w_misalign = (req_size == SZ_HALF && req_addr[0]) ||
                       (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
`else
   assign w_misalign = 1'b0;
`endif

   assign w_err = (req_size == SZ_ERR) || w_misalign ||
                  ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));

   assign req_ready  = (r_state == S_IDLE) && !rst;
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = r_resp_err;
   assign addr       = r_addr;
   assign data2      = r_data2;
   assign lw_en      = r_lw_en;
   assign sw_en      = r_sw_en;

   lsu_align u_align (
      .i_size     (r_size),
      .i_unsigned (r_unsigned),
      .i_off      (r_off),
      .i_rword    (data_mem),
      .i_wdata    (r_wdata),
      .o_ldata    (w_ldata),
      .o_mword    (w_mword)
   );

   // access sequencer; strobes are one-cycle registered pulses set on entry to their state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_we         <= 1'b0;
         r_size       <= SZ_BYTE;
         r_unsigned   <= 1'b0;
         r_off        <= 2'b00;
         r_wdata      <= 32'h0;
         r_addr       <= 32'h0;
         r_data2      <= 32'h0;
         r_lw_en      <= 1'b0;
         r_sw_en      <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= 32'h0;
      end else begin
         r_lw_en      <= 1'b0;
         r_sw_en      <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         case (r_state)
            S_IDLE: if (req_valid) begin
               r_we       <= req_we;
               r_size     <= req_size;
               r_unsigned <= req_unsigned;
               r_off      <= req_addr[1:0];
               r_wdata    <= req_wdata;
               r_addr     <= {2'b00, req_addr[31:2]};
               r_data2    <= req_wdata;
               if (w_err) begin
                  r_state      <= S_RESP;
                  r_resp_valid <= 1'b1;
                  r_resp_err   <= 1'b1;
                  r_resp_rdata <= 32'h0;
               end else if (req_we && req_size == SZ_WORD) begin
                  r_state <= S_WRITE;
                  r_sw_en <= 1'b1;
               end else begin
                  r_state <= S_SETUP;
               end
            end
            S_SETUP: begin
               r_state <= S_READ;
               r_lw_en <= 1'b1;
            end
            S_READ: if (r_we) begin
               r_state <= S_WRITE;
               r_sw_en <= 1'b1;
               r_data2 <= w_mword;
            end else begin
               r_state      <= S_RESP;
               r_resp_valid <= 1'b1;
               r_resp_rdata <= w_ldata;
            end
            S_WRITE: begin
               r_state      <= S_RESP;
               r_resp_valid <= 1'b1;
               r_resp_rdata <= 32'h0;
            end
            S_RESP: begin
               r_state      <= S_IDLE;
               r_resp_rdata <= 32'h0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of load/store sequencing, lanes, errors and reset abort.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] addr;
   logic [31:0] data2;
   logic        lw_en;
   logic        sw_en;
   logic [31:0] data_mem;

   logic [31:0] mem [256];
   logic [31:0] last_sw_addr = 32'h0;
   logic [31:0] prev_addr = 32'h0;
   logic        prev_sw = 1'b0;
   int          sw_cnt = 0;
   int          lw_cnt = 0;
   int          resp_cnt = 0;
   int          viol = 0;
   int          checks = 0;
   int          failures = 0;
   int          lat;
   logic        got;
   logic [31:0] rd;
   logic        er;
   int          sw0, lw0, rv0;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .addr         (addr),
      .data2        (data2),
      .lw_en        (lw_en),
      .sw_en        (sw_en),
      .data_mem     (data_mem)
   );

   assign data_mem = lw_en ? mem[addr[7:0]] : 32'h0;

   // memory commits on the falling edge; also watch strobe rules
   always @(negedge clk) begin
      if (sw_en) begin
         mem[addr[7:0]] <= data2;
         last_sw_addr   <= addr;
      end
      if (lw_en && addr != prev_addr) viol++;
      if (sw_en && prev_sw) viol++;
      prev_addr = addr;
      prev_sw   = sw_en;
   end

   always @(posedge clk) begin
      if (sw_en) sw_cnt++;
      if (lw_en) lw_cnt++;
      if (resp_valid) resp_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // issue one request from a negedge in IDLE; returns latency in cycles and response
   task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = a; req_wdata = wd;
      chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      got = 1'b0; lat = 0; rd = 32'hX; er = 1'bX;
      for (int i = 1; i <= 10 && !got; i++) begin
         @(negedge clk);
         if (resp_valid) begin
            got = 1'b1; lat = i; rd = resp_rdata; er = resp_err;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_ready", {31'h0, req_ready}, 32'h0);
      chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
      chk("rst_lw_sw", {30'h0, lw_en, sw_en}, 32'h0);
      chk("rst_addr", addr, 32'h0);
      chk("rst_data2", data2, 32'h0);
      chk("rst_rdata", resp_rdata, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      sw0 = sw_cnt;
      do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
      chk("sw_lat", 32'(lat), 32'd2);
      chk("sw_err", {31'h0, er}, 32'h0);
      chk("sw_rdata", rd, 32'h0);
      chk("sw_pulses", 32'(sw_cnt - sw0), 32'd1);
      chk("sw_addr", last_sw_addr, 32'd4);
      chk("sw_mem", mem[4], 32'hDEADBEEF);

      lw0 = lw_cnt;
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      chk("lw_lat", 32'(lat), 32'd3);
      chk("lw_rdata", rd, 32'hDEADBEEF);
      chk("lw_err", {31'h0, er}, 32'h0);
      chk("lw_pulses", 32'(lw_cnt - lw0), 32'd1);

      do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
      chk("lb_s", rd, 32'hFFFFFFDE);
      do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
      chk("lb_u", rd, 32'h000000DE);
      do_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
      chk("lh_s", rd, 32'hFFFFBEEF);
      do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
      chk("lh_u", rd, 32'h0000DEAD);

      sw0 = sw_cnt;
      do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234);
      chk("sh_lat", 32'(lat), 32'd4);
      chk("sh_mem", mem[4], 32'h1234BEEF);
      chk("sh_pulses", 32'(sw_cnt - sw0), 32'd1);
      do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFFAB);
      chk("sb_lat", 32'(lat), 32'd4);
      chk("sb_mem", mem[4], 32'h1234ABEF);

      lw0 = lw_cnt;
      do_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
      chk("oob_lat", 32'(lat), 32'd1);
      chk("oob_err", {31'h0, er}, 32'h1);
      chk("oob_rdata", rd, 32'h0);
      chk("oob_no_lw", 32'(lw_cnt - lw0), 32'd0);
      do_req(1'b1, 2'b10, 1'b0, 32'h3FC, 32'hCAFEF00D);
      chk("last_word_err", {31'h0, er}, 32'h0);
      chk("last_word_mem", mem[255], 32'hCAFEF00D);
      sw0 = sw_cnt;
      do_req(1'b1, 2'b10, 1'b0, 32'h400, 32'h5555AAAA);
      chk("oob_st_err", {31'h0, er}, 32'h1);
      chk("oob_no_sw", 32'(sw_cnt - sw0), 32'd0);
      do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
      chk("size11_lat", 32'(lat), 32'd1);
      chk("size11_err", {31'h0, er}, 32'h1);

      do_req(1'b0, 2'b10, 1'b0, 32'h11, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("mis_w_err", {31'h0, er}, 32'h1);
      chk("mis_w_rdata", rd, 32'h0);
`else
      chk("mis_w_err", {31'h0, er}, 32'h0);
      chk("mis_w_rdata", rd, 32'h1234ABEF);
`endif
      do_req(1'b0, 2'b01, 1'b0, 32'h13, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("mis_h_err", {31'h0, er}, 32'h1);
`else
      chk("mis_h_rdata", rd, 32'h00001234);
`endif

      do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h20; req_wdata = 32'h55;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort_in_read", {31'h0, lw_en}, 32'h1);
      sw0 = sw_cnt; rv0 = resp_cnt;
      rst = 1'b1;
      @(negedge clk);
      chk("abort_ready_rst", {31'h0, req_ready}, 32'h0);
      chk("abort_sw_rst", {31'h0, sw_en}, 32'h0);
      rst = 1'b0; #1;
      chk("abort_ready_after", {31'h0, req_ready}, 32'h1);
      repeat (5) @(negedge clk);
      chk("abort_no_sw", 32'(sw_cnt - sw0), 32'd0);
      chk("abort_no_resp", 32'(resp_cnt - rv0), 32'd0);
      chk("abort_mem", mem[8], 32'h11223344);
      do_req(1'b0, 2'b00, 1'b1, 32'h21, 32'h0);
      chk("post_abort_lb", rd, 32'h00000033);
      chk("strobe_rules", 32'(viol), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256: number of 32-bit words in the attached data memory.
REQ-002 SHALL have port clk  in  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1: reset, synchronous and active-high.
REQ-004 SHALL have port req_valid  in  1: CPU access request.
REQ-005 SHALL have port req_ready  out  1: request accepted on a rising edge where req_valid && req_ready.
REQ-006 SHALL have port req_we  in  1: 1 = store, 0 = load.
REQ-007 SHALL have port req_size  in  2: 00 byte, 01 half, 10 word; 11 treated as an error.
REQ-008 SHALL have port req_unsigned  in  1: loads only; 1 = zero-extend, 0 = sign-extend.
REQ-009 SHALL have port req_addr  in  32: byte address.
REQ-010 SHALL have port req_wdata  in  32: store data, right-aligned.
REQ-011 SHALL have port resp_valid  out  1: one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  out  32: extended load data, valid with resp_valid; 0 for stores.
REQ-013 SHALL have port resp_err  out  1: error flag, valid with resp_valid.
REQ-014 SHALL have port addr  out  32: memory word index (req_addr >> 2).
REQ-015 SHALL have port data2  out  32: memory write word.
REQ-016 SHALL have port lw_en  out  1: memory read enable (level).
REQ-017 SHALL have port sw_en  out  1: memory write enable; memory commits on falling clk edge.
REQ-018 SHALL have port data_mem  in  32: memory read word.

Function
REQ-019 SHALL implement FSM states IDLE, SETUP, READ, WRITE, RESP; req_ready = 1 only in IDLE with rst low.
REQ-020 SHALL register req fields at acceptance; addr is updated at the acceptance edge and held until return to IDLE.
REQ-021 SHALL sequence load as IDLE->SETUP->READ->RESP, so resp_valid rises in the 3rd cycle after acceptance.
REQ-022 SHALL sequence word store as IDLE->WRITE->RESP, with resp_valid in the 2nd cycle.
REQ-023 SHALL sequence byte/half store as IDLE->SETUP->READ->WRITE->RESP, using read-modify-write, with resp_valid in the 4th cycle.
REQ-024 SHALL assert lw_en only in READ, never in the same cycle addr changes, and return it to 0 between any two reads.
REQ-025 SHALL sample data_mem at the rising edge ending READ.
REQ-026 SHALL assert sw_en for exactly one cycle, in WRITE, with addr and data2 stable for that whole cycle.
REQ-027 SHALL use little-endian lanes: byte lane = req_addr[1:0]; half lane = req_addr[1].
REQ-028 SHALL, on a sub-word store, replace only the addressed lane(s) of the read word and preserve all other bits.
REQ-029 SHALL, on a sub-word load, extract the addressed lane and extend it per req_unsigned.
REQ-030 SHALL, on an error (word index >= MEM_WORDS or req_size==11), go IDLE->RESP with resp_err=1, resp_rdata=0, and no lw_en/sw_en.
REQ-031 SHALL return RESP->IDLE unconditionally; back-to-back requests are accepted on the edge leaving RESP+1 (IDLE).

Reset
REQ-032 SHALL, while rst is high, force state IDLE; req_ready, resp_valid, resp_err, lw_en and sw_en to 0; resp_rdata, addr and data2 to 0.
REQ-033 SHALL make rst mid-operation abort the access: no sw_en after the reset edge, no resp_valid for the aborted request.

Configuration
REQ-034 SHALL, with LSU_MISALIGN_TRAP_EN defined, treat half access with addr[0]=1 or word access with addr[1:0]!=0 as an error per REQ-030.
REQ-035 SHALL, without LSU_MISALIGN_TRAP_EN, silently align these accesses: half clears bit0, word clears bits[1:0]; no error.

Structure
REQ-036 SHALL place size encodings, FSM state encoding and the MEM_WORDS default in shared package lsu_pkg.
REQ-037 SHALL use one combinational sub-module lsu_align that performs lane extract/extend and lane merge.

Verification
REQ-038 SHALL cover: word store addr 0x10, data 0xDEADBEEF, then word load 0x10 -> sw_en 1 cycle at addr 4; resp_rdata 0xDEADBEEF, 3 cycles after acceptance.
REQ-039 SHALL cover: memory word4=0xDEADBEEF, signed byte load 0x13 -> 0xFFFFFFDE; unsigned -> 0x000000DE.
REQ-040 SHALL cover: word4=0xDEADBEEF, half store 0x12 data 0x1234 -> word4 = 0x1234BEEF, resp in 4th cycle.
REQ-041 SHALL cover: load 0x400 (index 256) -> resp_err=1 next cycle, lw_en never high.
REQ-042 SHALL cover: word load 0x11 -> err=1 with macro; without macro, data of word4.
REQ-043 SHALL cover: rst asserted during READ of a byte store -> no sw_en, no resp_valid, req_ready=1 the cycle after rst drops.
